jk_bank_seq: RTL and testbench
==============================

# jk_bank_seq

Command sequencer for a bank of `WIDTH` JK flip-flops. It accepts hold/reset/set/toggle commands over a valid/ready handshake and drives the bank's J/K vectors for a programmable number of clock edges. It keeps a shadow model of the expected bank state and checks the bank's Q outputs against it after every command. It sits between a test/config master and the flip-flop bank; the bank's Q vector is fed back to this block.

## Interface
- `WIDTH`, default 4: number of JK flip-flops in the bank.
- `CNT_W`, default 4: width of the per-command edge count.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted on a cycle with `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  operation: 00 hold (J=0,K=0), 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1).
- `cmd_mask`  in  WIDTH  bits the operation applies to.
- `cmd_count`  in  CNT_W  number of edges to apply; 0 is treated as 1.
- `err_clr`  in  1  clears the sticky `err` flag.
- `jk_j`  out  WIDTH  registered J vector to the bank.
- `jk_k`  out  WIDTH  registered K vector to the bank.
- `jk_q`  in  WIDTH  Q vector from the bank.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of each command.
- `err`  out  1  sticky mismatch flag.
- `err_bits`  out  WIDTH  mismatch vector from the most recent check.
- `exp_q`  out  WIDTH  shadow model of the expected bank state.

## Operation
- **States:** IDLE, DRIVE, CHECK.
- **IDLE**
  - `cmd_ready`=1 and `jk_j`=`jk_k`=0.
  - On handshake: latch `cmd_op` and `cmd_mask`, set the edge counter to max(`cmd_count`,1)−1, go to DRIVE.
  - `cmd_valid` outside IDLE is ignored, not queued.
- **DRIVE**
  - Per bit: J/K are driven per the latched op where the mask bit is 1; J=K=0 where it is 0.
  - Each DRIVE cycle updates `exp_q` for masked bits: hold keeps the bit, reset clears it, set sets it, toggle inverts it.
  - When the counter is 0, go to CHECK; otherwise decrement it.
- **CHECK**
  - `jk_j`=`jk_k`=0.
  - Register `err_bits` <= `jk_q ^ exp_q`.
  - If that value is non-zero, set `err`.
  - Assert `done` on the next cycle and return to IDLE.
- **`err` behaviour**
  - `err` is sticky until `rst` or `err_clr`.
  - If `err_clr` and a new mismatch occur in the same cycle, set wins.
- **Reset mapping:** the bank is reset in the same cycle as this block; `exp_q` resets to 0 to match.
- **Toggle parity:** toggle with an even count leaves `exp_q` unchanged; with an odd count it inverts the masked bits.

## Timing
- **Reset:** with `rst`=0 at an edge, after that edge the block holds:
  - state IDLE;
  - `jk_j`=`jk_k`=0, `exp_q`=0, `err_bits`=0;
  - `done`=0, `err`=0, `busy`=0, `cmd_ready`=1.
- **Command timeline** (handshake in cycle T, n = max(`cmd_count`,1)):
  - J/K are valid in cycles T+1 … T+n.
  - The bank samples them at the edges closing those cycles.
  - CHECK is in cycle T+n+1, where `jk_q` reflects all n edges.
  - `done`=1 in cycle T+n+2, with `err_bits`/`err` valid in the same cycle.
- **Latency:** handshake to `done` is n+2 cycles.
- **Back-to-back:** `cmd_ready` is 1 in the `done` cycle, so the next command may be accepted there. Minimum command period is n+2 cycles.
- **Reset mid-command:** `rst`=0 in DRIVE or CHECK aborts the command. Outputs take their reset values after that edge and no `done` is issued.
- **Counter range:** the edge counter is CNT_W bits and never wraps; the maximum count is 2^CNT_W−1 edges.

## Test plan
Directed scenarios, WIDTH=4.

1. **Reset:** hold `rst`=0 for 2 cycles with `cmd_valid`=1 → `jk_j`=`jk_k`=0000, `cmd_ready`=1, `busy`=0, `done`=0, `err`=0, `exp_q`=0000, no command accepted.
2. **Set:** op=10, mask=0101, count=1, handshake at T → `jk_j`=0101 and `jk_k`=0000 in T+1; `done` at T+3; `exp_q`=0101, `jk_q`=0101, `err_bits`=0000.
3. **Toggle:** from 0101, op=11, mask=1111, count=3 → J=K=1111 for T+1..T+3; `done` at T+5; `exp_q`=`jk_q`=1010. Then count=2 → result unchanged at 1010. Then count=0 → behaves as 1 edge, `done` at T+3, result 0101.
4. **Fault:** force bank bit 2 stuck at 0, then op=10, mask=0100 → `err_bits`=0100 and `err`=1 in the `done` cycle. `err` stays 1 through a following clean command; `err_clr` pulse → `err`=0. `err_clr` coincident with a new mismatch → `err` stays 1.
5. **Handshake:** hold `cmd_valid`=1 during DRIVE with a different op → ignored and `exp_q` unaffected; second command accepted in the `done` cycle of the first.
6. **Mid-command reset:** op=11, mask=1111, count=8, assert `rst`=0 in the 4th DRIVE cycle → J/K = 0000 after that edge, no `done` pulse, `exp_q`=0000, `cmd_ready`=1 after release.

Source files
------------

// File: rtl/jk_bank_seq.sv
// jk_bank_seq: command sequencer for a bank of WIDTH JK flip-flops.
// Accepts hold/reset/set/toggle commands over a valid/ready handshake, drives
// registered J/K vectors for a programmable number of edges, keeps a shadow
// model of the bank and compares it with the bank's Q after every command.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   cmd_valid_i  command request
//   cmd_ready_o  high only in idle; handshake = cmd_valid_i & cmd_ready_o
//   cmd_op_i     00 hold, 01 reset, 10 set, 11 toggle
//   cmd_mask_i   bits the operation applies to
//   cmd_count_i  number of edges to apply (0 behaves as 1)
//   err_clr_i    clears the sticky error flag
//   jk_j_o       registered J vector to the bank
//   jk_k_o       registered K vector to the bank
//   jk_q_i       Q vector from the bank
//   busy_o       high whenever not idle
//   done_o       one-cycle pulse at the end of each command
//   err_o        sticky mismatch flag
//   err_bits_o   mismatch vector from the most recent check
//   exp_q_o      shadow model of the expected bank state
module jk_bank_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_mask_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  input  logic             err_clr_i,
  output logic [WIDTH-1:0] jk_j_o,
  output logic [WIDTH-1:0] jk_k_o,
  input  logic [WIDTH-1:0] jk_q_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] err_bits_o,
  output logic [WIDTH-1:0] exp_q_o
);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] err_bits_q, err_bits_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    j_d        = '0;
    k_d        = '0;
    exp_d      = exp_q;
    err_bits_d = err_bits_q;
    err_d      = err_q & ~err_clr_i;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          mask_d  = cmd_mask_i;
          // Counter holds remaining edges minus one; a count of 0 runs one edge.
          cnt_d   = (cmd_count_i == '0) ? '0 : cmd_count_i - CNT_W'(1);
          // J/K are registered, so the first drive value is loaded at the handshake.
          j_d     = cmd_mask_i & {WIDTH{cmd_op_i[1]}};
          k_d     = cmd_mask_i & {WIDTH{cmd_op_i[0]}};
          state_d = StDrive;
        end
      end
      StDrive: begin
        // The bank samples this cycle's J/K at the closing edge; mirror that here.
        unique case (op_q)
          2'b00: exp_d = exp_q;
          2'b01: exp_d = exp_q & ~mask_q;
          2'b10: exp_d = exp_q | mask_q;
          2'b11: exp_d = exp_q ^ mask_q;
        endcase
        if (cnt_q == '0) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          j_d   = mask_q & {WIDTH{op_q[1]}};
          k_d   = mask_q & {WIDTH{op_q[0]}};
        end
      end
      StCheck: begin
        err_bits_d = jk_q_i ^ exp_q;
        // A new mismatch wins over a coincident clear.
        if (|err_bits_d) err_d = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      mask_q     <= '0;
      cnt_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      exp_q      <= '0;
      err_bits_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      exp_q      <= exp_d;
      err_bits_q <= err_bits_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign jk_j_o      = j_q;
  assign jk_k_o      = k_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_bits_o  = err_bits_q;
  assign exp_q_o     = exp_q;

endmodule

// File: tb/tb_jk_bank_seq.sv
// Self-checking bench for jk_bank_seq (WIDTH=4, CNT_W=4). A behavioural JK bank
// with an optional stuck-at-0 output mask closes the loop. Expected results are
// queued at each handshake and popped by a monitor when done pulses.
module tb_jk_bank_seq;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [3:0] cmd_count;
  logic       err_clr;
  logic [3:0] jk_j;
  logic [3:0] jk_k;
  logic [3:0] jk_q;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] err_bits;
  logic [3:0] exp_q;

  logic [3:0] bank;
  logic [3:0] stuck;
  int         cyc;
  int         n_vec;
  int         n_bad;

  typedef struct {
    logic [1:0] op;
    logic [3:0] mask;
    logic [3:0] cnt;
    int         clr;    // 0 none, 1 pulse before command, 2 during check cycle
    logic [3:0] stuck;
    logic [3:0] eq;
    logic [3:0] eb;
    logic       er;
  } vec_t;

  typedef struct {
    logic [3:0] eq;
    logic [3:0] eb;
    logic       er;
    int         dc;
  } sb_t;

  vec_t tbl[16];
  sb_t  sb[$];

  jk_bank_seq #(.WIDTH(4), .CNT_W(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i   (cmd_op),
    .cmd_mask_i (cmd_mask),
    .cmd_count_i(cmd_count),
    .err_clr_i  (err_clr),
    .jk_j_o     (jk_j),
    .jk_k_o     (jk_k),
    .jk_q_i     (jk_q),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .err_bits_o (err_bits),
    .exp_q_o    (exp_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural JK bank, reset together with the sequencer.
  always @(posedge clk) begin
    if (!rst_n) bank <= 4'b0000;
    else begin
      for (int i = 0; i < 4; i++) begin
        case ({jk_j[i], jk_k[i]})
          2'b01:   bank[i] <= 1'b0;
          2'b10:   bank[i] <= 1'b1;
          2'b11:   bank[i] <= ~bank[i];
          default: ;
        endcase
      end
    end
  end
  assign jk_q = bank & ~stuck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    sb_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done_queue_depth", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.dc));
        chk("exp_q", {28'd0, exp_q}, {28'd0, e.eq});
        chk("err_bits", {28'd0, err_bits}, {28'd0, e.eb});
        chk("err", {31'd0, err}, {31'd0, e.er});
      end
    end
  end

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic do_cmd(input int idx, input vec_t v);
    int n;
    n = (v.cnt == 4'd0) ? 1 : int'(v.cnt);
    stuck = v.stuck;
    if (v.clr == 1) begin
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
    end
    chk($sformatf("v%0d_ready", idx), {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_mask  = v.mask;
    cmd_count = v.cnt;
    sb.push_back('{eq: v.eq, eb: v.eb, er: v.er, dc: cyc + n + 2});
    @(negedge clk);
    cmd_valid = 1'b0;
    chk($sformatf("v%0d_j", idx), {28'd0, jk_j}, {28'd0, v.mask & {4{v.op[1]}}});
    chk($sformatf("v%0d_k", idx), {28'd0, jk_k}, {28'd0, v.mask & {4{v.op[0]}}});
    chk($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
    repeat (n) @(negedge clk);
    chk($sformatf("v%0d_check_jk", idx), {24'd0, jk_j, jk_k}, 32'd0);
    if (v.clr == 2) err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    wait_drain(4);
  endtask

  initial begin : gtimeout
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin : main
    int ta;
    int acc;
    n_vec = 0;
    n_bad = 0;

    tbl[0]  = '{2'b10, 4'b0101, 4'd1,  0, 4'b0000, 4'b0101, 4'b0000, 1'b0};
    tbl[1]  = '{2'b11, 4'b1111, 4'd3,  0, 4'b0000, 4'b1010, 4'b0000, 1'b0};
    tbl[2]  = '{2'b11, 4'b1111, 4'd2,  0, 4'b0000, 4'b1010, 4'b0000, 1'b0};
    tbl[3]  = '{2'b11, 4'b1111, 4'd0,  0, 4'b0000, 4'b0101, 4'b0000, 1'b0};
    tbl[4]  = '{2'b01, 4'b1111, 4'd1,  0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[5]  = '{2'b00, 4'b1111, 4'd5,  0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[6]  = '{2'b10, 4'b1111, 4'd15, 0, 4'b0000, 4'b1111, 4'b0000, 1'b0};
    tbl[7]  = '{2'b01, 4'b1010, 4'd2,  0, 4'b0000, 4'b0101, 4'b0000, 1'b0};
    tbl[8]  = '{2'b01, 4'b1111, 4'd1,  0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{2'b10, 4'b0100, 4'd1,  0, 4'b0100, 4'b0100, 4'b0100, 1'b1};
    tbl[10] = '{2'b01, 4'b0100, 4'd1,  0, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    tbl[11] = '{2'b00, 4'b0001, 4'd1,  1, 4'b0100, 4'b0000, 4'b0000, 1'b0};
    tbl[12] = '{2'b10, 4'b0100, 4'd1,  0, 4'b0100, 4'b0100, 4'b0100, 1'b1};
    tbl[13] = '{2'b10, 4'b0100, 4'd1,  2, 4'b0100, 4'b0100, 4'b0100, 1'b1};
    tbl[14] = '{2'b01, 4'b0100, 4'd1,  2, 4'b0100, 4'b0000, 4'b0000, 1'b0};
    tbl[15] = '{2'b11, 4'b0110, 4'd1,  0, 4'b0000, 4'b0110, 4'b0000, 1'b0};

    // Reset held for two edges with a pending request.
    rst_n     = 1'b0;
    stuck     = 4'b0000;
    err_clr   = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_mask  = 4'b1111;
    cmd_count = 4'd1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_jk", {24'd0, jk_j, jk_k}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_exp_q", {28'd0, exp_q}, 32'd0);
    chk("rst_err_bits", {28'd0, err_bits}, 32'd0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("post_rst_not_accepted", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 16; i++) do_cmd(i, tbl[i]);

    // Request held through DRIVE with a different op: ignored until done cycle.
    @(negedge clk);
    ta        = cyc;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_mask  = 4'b0011;
    cmd_count = 4'd2;
    sb.push_back('{eq: 4'b0111, eb: 4'b0000, er: 1'b0, dc: ta + 4});
    @(negedge clk);
    chk("b2b_first_j", {28'd0, jk_j}, 32'h3);
    cmd_op    = 2'b11;
    cmd_mask  = 4'b1111;
    cmd_count = 4'd1;
    acc       = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc;
        sb.push_back('{eq: 4'b1000, eb: 4'b0000, er: 1'b0, dc: cyc + 3});
        break;
      end
    end
    chk("b2b_accept_cycle", 32'(acc), 32'(ta + 4));
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_drain(8);

    // Reset in the 4th DRIVE cycle of an 8-edge toggle aborts without done.
    @(negedge clk);
    ta        = cyc;
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_mask  = 4'b1111;
    cmd_count = 4'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_exp_q", {28'd0, exp_q}, 32'h7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_jk", {24'd0, jk_j, jk_k}, 32'd0);
    chk("abort_exp_q", {28'd0, exp_q}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_busy_after", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
